// File: rtl/cdb_pkg.sv
// Shared CDB definitions used by the FU output buffers and the CDB arbiter.
package cdb_pkg;

    localparam int CDB_N_REQ = 4;
    localparam int CDB_IDX_W = (CDB_N_REQ > 1) ? $clog2(CDB_N_REQ) : 1;

    typedef logic [CDB_IDX_W-1:0] cdb_req_idx_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating find-first: first set request at or above priority_ptr, wrapping to 0.
module rr_priority_encoder #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] request,
    input  logic [W-1:0] priority_ptr,
    output logic         found,
    output logic [W-1:0] index
);

    localparam logic [W:0] N_EXT = (W+1)'(N);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [W-1:0]   offset;
    logic [W:0]     sum;

    always_comb begin
        doubled = {request, request};
        // Bit k of rotated is request[(priority_ptr + k) mod N].
        rotated = N'(doubled >> priority_ptr);
        found   = |rotated;
        offset  = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = W'(i);
            end
        end
        sum   = {1'b0, priority_ptr} + {1'b0, offset};
        index = (sum >= N_EXT) ? W'(sum - N_EXT) : W'(sum);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: zero-latency one-hot permit, rotating priority pointer
// and a broadcast counter.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ = CDB_N_REQ,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic             cdb_enable,
    output logic [N_REQ-1:0] permit,
    output logic             cdb_valid,
    output logic [IDX_W-1:0] grant_index,
    output logic [IDX_W-1:0] priority_ptr,
    output logic [CNT_W-1:0] broadcast_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic             found;
    logic [IDX_W-1:0] winner;
    logic             grant;

    rr_priority_encoder #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_encoder (
        .request      (request),
        .priority_ptr (priority_ptr),
        .found        (found),
        .index        (winner)
    );

    // Reset suppresses the grant so no buffer retires an entry while in reset.
    assign grant = !reset && cdb_enable && found;

    always_comb begin
        permit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            permit[i] = grant && (winner == IDX_W'(i));
        end
    end

    assign cdb_valid   = grant;
    assign grant_index = grant ? winner : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            priority_ptr    <= '0;
            broadcast_count <= '0;
        end else if (grant) begin
            // Explicit wrap so non-power-of-two N_REQ never reaches an unused index.
            priority_ptr    <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
            broadcast_count <= broadcast_count + CNT_W'(1);
        end
    end

    a_permit_onehot0 : assert property (@(posedge clk) $onehot0(permit));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: 4-requester, 3-requester and 2-buffer integration instances.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic        clk;
    logic        reset;

    logic [3:0]  request4;
    logic        enable4;
    logic [3:0]  permit4;
    logic        valid4;
    logic [1:0]  gidx4;
    logic [1:0]  ptr4;
    logic [31:0] count4;

    logic [2:0]  request3;
    logic        enable3;
    logic [2:0]  permit3;
    logic        valid3;
    logic [1:0]  gidx3;
    logic [1:0]  ptr3;
    logic [31:0] count3;

    logic [1:0]  request2;
    logic        enable2;
    logic [1:0]  permit2;
    logic        valid2;
    logic [0:0]  gidx2;
    logic [0:0]  ptr2;
    logic [31:0] count2;

    int n_vec;
    int n_err;

    logic [7:0] buf0_q[$];
    logic [7:0] buf1_q[$];

    cdb_arbiter #(.N_REQ(4)) u_dut4 (
        .clk             (clk),
        .reset           (reset),
        .request         (request4),
        .cdb_enable      (enable4),
        .permit          (permit4),
        .cdb_valid       (valid4),
        .grant_index     (gidx4),
        .priority_ptr    (ptr4),
        .broadcast_count (count4)
    );

    cdb_arbiter #(.N_REQ(3)) u_dut3 (
        .clk             (clk),
        .reset           (reset),
        .request         (request3),
        .cdb_enable      (enable3),
        .permit          (permit3),
        .cdb_valid       (valid3),
        .grant_index     (gidx3),
        .priority_ptr    (ptr3),
        .broadcast_count (count3)
    );

    cdb_arbiter #(.N_REQ(2)) u_dut2 (
        .clk             (clk),
        .reset           (reset),
        .request         (request2),
        .cdb_enable      (enable2),
        .permit          (permit2),
        .cdb_valid       (valid2),
        .grant_index     (gidx2),
        .priority_ptr    (ptr2),
        .broadcast_count (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle on the 4-requester instance: drive, check grant, clock, check state.
    task automatic cycle4(input string name, input logic [3:0] req, input logic en,
                          input logic [3:0] exp_permit, input logic [1:0] exp_idx,
                          input logic [1:0] exp_ptr, input logic [31:0] exp_count);
        @(negedge clk);
        request4 = req;
        enable4  = en;
        #1;
        n_vec++;
        if (permit4 !== exp_permit) begin
            n_err++;
            $display("FAIL %s permit got %b expected %b", name, permit4, exp_permit);
        end
        n_vec++;
        if (valid4 !== (exp_permit != 4'b0000) || gidx4 !== exp_idx) begin
            n_err++;
            $display("FAIL %s valid/index got %b/%0d expected %b/%0d", name, valid4, gidx4,
                     (exp_permit != 4'b0000), exp_idx);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (ptr4 !== exp_ptr || count4 !== exp_count) begin
            n_err++;
            $display("FAIL %s ptr/count got %0d/%0d expected %0d/%0d", name, ptr4, count4,
                     exp_ptr, exp_count);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        request4 = 4'b1111;
        enable4  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (permit4 !== 4'b0000 || valid4 !== 1'b0 || gidx4 !== 2'd0) begin
                n_err++;
                $display("FAIL reset_gate permit/valid/index got %b/%b/%0d expected 0000/0/0",
                         permit4, valid4, gidx4);
            end
        end
        @(negedge clk);
        reset    = 1'b0;
        request4 = 4'b0000;
        #1;
        n_vec++;
        if (ptr4 !== 2'd0 || count4 !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state ptr/count got %0d/%0d expected 0/0", ptr4, count4);
        end
    endtask

    task automatic test_all_requesting();
        logic [3:0] exp_p;
        for (int k = 0; k < 4; k++) begin
            exp_p = 4'b0001 << k;
            cycle4("all_req", 4'b1111, 1'b1, exp_p, 2'(k), 2'((k + 1) % 4), 32'(k + 1));
        end
    endtask

    task automatic test_wrap_skip();
        cycle4("wrap_setup", 4'b0100, 1'b1, 4'b0100, 2'd2, 2'd3, 32'd5);
        cycle4("wrap_skip", 4'b0011, 1'b1, 4'b0001, 2'd0, 2'd1, 32'd6);
        cycle4("wrap_next", 4'b0011, 1'b1, 4'b0010, 2'd1, 2'd2, 32'd7);
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            cycle4("stall", 4'b0100, 1'b0, 4'b0000, 2'd0, 2'd2, 32'd7);
        end
        cycle4("stall_release", 4'b0100, 1'b1, 4'b0100, 2'd2, 2'd3, 32'd8);
    endtask

    task automatic test_back_to_back();
        cycle4("b2b_first", 4'b1000, 1'b1, 4'b1000, 2'd3, 2'd0, 32'd9);
        cycle4("b2b_demoted", 4'b1001, 1'b1, 4'b0001, 2'd0, 2'd1, 32'd10);
        cycle4("b2b_other", 4'b1001, 1'b1, 4'b1000, 2'd3, 2'd0, 32'd11);
        cycle4("b2b_alone", 4'b1000, 1'b1, 4'b1000, 2'd3, 2'd0, 32'd12);
        cycle4("b2b_alone2", 4'b1000, 1'b1, 4'b1000, 2'd3, 2'd0, 32'd13);
    endtask

    task automatic test_mid_reset();
        cycle4("pre_reset", 4'b0010, 1'b1, 4'b0010, 2'd1, 2'd2, 32'd14);
        @(negedge clk);
        reset    = 1'b1;
        request4 = 4'b1111;
        #1;
        n_vec++;
        if (permit4 !== 4'b0000 || valid4 !== 1'b0 || gidx4 !== 2'd0) begin
            n_err++;
            $display("FAIL mid_reset_gate permit/valid/index got %b/%b/%0d expected 0000/0/0",
                     permit4, valid4, gidx4);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (ptr4 !== 2'd0 || count4 !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_state ptr/count got %0d/%0d expected 0/0", ptr4, count4);
        end
        @(negedge clk);
        reset    = 1'b0;
        request4 = 4'b0000;
        cycle4("post_reset", 4'b0100, 1'b1, 4'b0100, 2'd2, 2'd3, 32'd1);
    endtask

    task automatic test_non_pow2();
        logic [2:0] exp_p;
        int         w;
        for (int k = 0; k < 4; k++) begin
            w = k % 3;
            exp_p = 3'b001 << w;
            @(negedge clk);
            request3 = 3'b111;
            enable3  = 1'b1;
            #1;
            n_vec++;
            if (permit3 !== exp_p || gidx3 !== 2'(w)) begin
                n_err++;
                $display("FAIL npow2_grant permit/index got %b/%0d expected %b/%0d",
                         permit3, gidx3, exp_p, w);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (ptr3 !== 2'((w + 1) % 3) || count3 !== 32'(k + 1)) begin
                n_err++;
                $display("FAIL npow2_ptr ptr/count got %0d/%0d expected %0d/%0d",
                         ptr3, count3, (w + 1) % 3, k + 1);
            end
        end
        @(negedge clk);
        request3 = 3'b000;
    endtask

    task automatic test_integration();
        logic [7:0] exp_q[$];
        logic [7:0] bus_tag;
        logic [1:0] seen;
        buf0_q = '{8'hA0, 8'hA1};
        buf1_q = '{8'hB0, 8'hB1};
        exp_q  = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        enable2 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            request2 = {buf1_q.size() != 0, buf0_q.size() != 0};
            #1;
            seen    = permit2;
            bus_tag = 8'h00;
            if (seen[0] && buf0_q.size() != 0) bus_tag = buf0_q[0];
            if (seen[1] && buf1_q.size() != 0) bus_tag = buf1_q[0];
            n_vec++;
            if (valid2 !== 1'b1 || bus_tag !== exp_q[c]) begin
                n_err++;
                $display("FAIL integ_tag cycle %0d valid/tag got %b/%h expected 1/%h",
                         c, valid2, bus_tag, exp_q[c]);
            end
            @(posedge clk);
            if (seen[0] && buf0_q.size() != 0) void'(buf0_q.pop_front());
            if (seen[1] && buf1_q.size() != 0) void'(buf1_q.pop_front());
        end
        @(negedge clk);
        request2 = {buf1_q.size() != 0, buf0_q.size() != 0};
        #1;
        n_vec++;
        if (buf0_q.size() != 0 || buf1_q.size() != 0 || valid2 !== 1'b0 || count2 !== 32'd4) begin
            n_err++;
            $display("FAIL integ_drain sizes/valid/count got %0d/%0d/%b/%0d expected 0/0/0/4",
                     buf0_q.size(), buf1_q.size(), valid2, count2);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        request4 = 4'b0000;
        enable4  = 1'b1;
        request3 = 3'b000;
        enable3  = 1'b1;
        request2 = 2'b00;
        enable2  = 1'b1;

        test_reset();
        test_all_requesting();
        test_wrap_skip();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_non_pow2();
        test_integration();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
